// File: rtl/attractor_pkg.sv
// ============================================================================
// Module   : attractor_pkg
// Purpose  : Shared result-class codes and sweep FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package attractor_pkg;

    localparam logic [1:0] CLS_NONE  = 2'd0;
    localparam logic [1:0] CLS_FIXED = 2'd1;
    localparam logic [1:0] CLS_CYCLE = 2'd2;
    localparam logic [1:0] CLS_UNRES = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STEP   = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/traj_history.sv
// ============================================================================
// Module   : traj_history
// Purpose  : Trajectory store with parallel probe compare and lowest-hit lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traj_history #(
    parameter int N     = 8,
    parameter int DEPTH = 16,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [N-1:0]  wr_data,
    input  logic [N-1:0]  probe,
    output logic          hit,
    output logic [IW-1:0] hit_idx,
    output logic [N-1:0]  hit_data
);

    logic [N-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] w_match;

    // A clear and a write in the same cycle leave only the written entry valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (clr) begin
                r_vld <= '0;
            end
            if (wr_en) begin
                r_vld[wr_idx] <= 1'b1;
                r_mem[wr_idx] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign w_match[g] = r_vld[g] && (r_mem[g] == probe);
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign hit_data = r_mem[hit_idx];

endmodule

`default_nettype wire

// File: rtl/attractor_sweeper.sv
// ============================================================================
// Module   : attractor_sweeper
// Purpose  : Sweeps all start states of an external Boolean network and
//            classifies each trajectory as fixed point, cycle or unresolved.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module attractor_sweeper
    import attractor_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  net_state_o,
    input  logic [N-1:0]  net_next_i,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_init,
    output logic [1:0]    res_class,
    output logic [PW-1:0] res_period,
    output logic [PW-1:0] res_transient,
    output logic [N-1:0]  res_attractor,
    output logic [N:0]    fixed_cnt,
    output logic [N:0]    cycle_cnt,
    output logic [N:0]    unres_cnt
);

    localparam int IW = $clog2(DEPTH);

    state_t        r_state;
    logic [N-1:0]  r_init;
    logic [IW-1:0] r_k;

    logic          w_hit;
    logic [IW-1:0] w_hit_idx;
    logic [N-1:0]  w_hit_data;
    logic          w_last;
    logic          w_clr;
    logic          w_wr_en;
    logic [IW-1:0] w_wr_idx;
    logic [N-1:0]  w_wr_data;
    logic [PW-1:0] w_period;

    assign w_last    = (r_k == IW'(DEPTH - 1));
    assign w_period  = PW'(r_k) + PW'(1) - PW'(w_hit_idx);
    assign w_clr     = (r_state == ST_LOAD);
    assign w_wr_en   = w_clr || ((r_state == ST_STEP) && !w_hit && !w_last);
    assign w_wr_idx  = w_clr ? '0 : r_k + IW'(1);
    assign w_wr_data = w_clr ? r_init : net_next_i;
    assign res_init  = r_init;

    traj_history #(
        .N     (N),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .wr_en    (w_wr_en),
        .wr_idx   (w_wr_idx),
        .wr_data  (w_wr_data),
        .probe    (net_next_i),
        .hit      (w_hit),
        .hit_idx  (w_hit_idx),
        .hit_data (w_hit_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_init        <= '0;
            r_k           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            net_state_o   <= '0;
            res_valid     <= 1'b0;
            res_class     <= CLS_NONE;
            res_period    <= '0;
            res_transient <= '0;
            res_attractor <= '0;
            fixed_cnt     <= '0;
            cycle_cnt     <= '0;
            unres_cnt     <= '0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_LOAD;
                        r_init    <= '0;
                        busy      <= 1'b1;
                        fixed_cnt <= '0;
                        cycle_cnt <= '0;
                        unres_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    net_state_o <= r_init;
                    r_k         <= '0;
                    r_state     <= ST_STEP;
                end
                ST_STEP: begin
                    if (w_hit) begin
                        res_class     <= (w_period == PW'(1)) ? CLS_FIXED : CLS_CYCLE;
                        res_period    <= w_period;
                        res_transient <= PW'(w_hit_idx);
                        res_attractor <= w_hit_data;
                        res_valid     <= 1'b1;
                        r_state       <= ST_REPORT;
                    end else if (w_last) begin
                        res_class     <= CLS_UNRES;
                        res_period    <= '0;
                        res_transient <= '0;
                        res_attractor <= '0;
                        res_valid     <= 1'b1;
                        r_state       <= ST_REPORT;
                    end else begin
                        net_state_o <= net_next_i;
                        r_k         <= r_k + IW'(1);
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        unique case (res_class)
                            CLS_FIXED: fixed_cnt <= fixed_cnt + (N+1)'(1);
                            CLS_CYCLE: cycle_cnt <= cycle_cnt + (N+1)'(1);
                            default:   unres_cnt <= unres_cnt + (N+1)'(1);
                        endcase
                        if (r_init == {N{1'b1}}) begin
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_init  <= r_init + N'(1);
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
